// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: captures renderer pixel writes into a 3-bit framebuffer and
// scans it out as VGA using a divide-by-2 pixel enable in the system clock domain.
module vga_frame_scanner #(
    parameter int         FB_W      = 361,
    parameter int         FB_H      = 241,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         H_ACTIVE  = 640,
    parameter int         H_FP      = 16,
    parameter int         H_SYNC    = 96,
    parameter int         H_BP      = 48,
    parameter int         V_ACTIVE  = 480,
    parameter int         V_FP      = 10,
    parameter int         V_SYNC    = 2,
    parameter int         V_BP      = 33
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [2:0] colour,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic       plot,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK,
    output logic       fb_ready,
    output logic [7:0] drop_count
);
    localparam int DEPTH = FB_W * FB_H;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [16:0] W17 = 17'(FB_W);
    localparam logic [9:0] FW = 10'(FB_W);
    localparam logic [9:0] FH = 10'(FB_H);
    localparam logic [9:0] HA = 10'(H_ACTIVE);
    localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VA = 10'(V_ACTIVE);
    localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state;
    logic [AW-1:0] clr_addr;
    logic [2:0]    mem [DEPTH];
    logic          in_range;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic          pix_en;
    logic [9:0]    hcnt;
    logic [9:0]    vcnt;
    logic          in_fb;
    logic [AW-1:0] rd_addr;
    logic [2:0]    rd_data;
    logic [2:0]    pix;
    logic          act_q;
    logic          infb_q;
    logic          hs_q;
    logic          vs_q;

    always_comb begin
        in_range = x < FW && {1'b0, y} < FH;
        we = resetn && (state == CLEAR || (plot && in_range));
        wr_addr = state == CLEAR ? clr_addr : AW'(17'(y) * W17 + 17'(x));
        wr_data = state == CLEAR ? BG_COLOUR : colour;
    end

    // Read port runs every clock so data is ready before the next pixel tick.
    always_ff @(posedge clock) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= CLEAR;
            clr_addr <= '0;
            fb_ready <= 1'b0;
            drop_count <= '0;
        end else begin
            fb_ready <= state == RUN;
            if (state == CLEAR) begin
                clr_addr <= clr_addr + AW'(1);
                if (clr_addr == LAST) state <= RUN;
            end else if (plot && !in_range && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    assign in_fb = hcnt < FW && vcnt < FH;
    assign pix = infb_q ? rd_data : BG_COLOUR;
    assign VGA_SYNC_N = 1'b0;

    // Counters -> address/flags -> outputs, each stage advancing on pixel ticks.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pix_en <= 1'b0;
            VGA_CLK <= 1'b0;
            hcnt <= '0;
            vcnt <= '0;
            rd_addr <= '0;
            act_q <= 1'b0;
            infb_q <= 1'b0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
            VGA_HS <= 1'b1;
            VGA_VS <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else begin
            pix_en <= !pix_en;
            VGA_CLK <= !pix_en;
            if (pix_en) begin
                hcnt <= hcnt == H_LAST ? '0 : hcnt + 10'd1;
                if (hcnt == H_LAST) vcnt <= vcnt == V_LAST ? '0 : vcnt + 10'd1;
                act_q <= hcnt < HA && vcnt < VA;
                infb_q <= in_fb;
                rd_addr <= in_fb ? AW'(17'(vcnt) * W17 + 17'(hcnt)) : '0;
                hs_q <= !(hcnt >= HS0 && hcnt < HS1);
                vs_q <= !(vcnt >= VS0 && vcnt < VS1);
                VGA_R <= act_q ? {8{pix[2]}} : 8'h00;
                VGA_G <= act_q ? {8{pix[1]}} : 8'h00;
                VGA_B <= act_q ? {8{pix[0]}} : 8'h00;
                VGA_HS <= hs_q;
                VGA_VS <= vs_q;
                VGA_BLANK_N <= act_q;
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: randomized bench for a shrunken-geometry scanner,
// checked against a position-based model of the picture and framebuffer.
module tb_vga_frame_scanner;
    localparam int W = 21, H = 13;
    localparam int HA = 40, HFP = 4, HSY = 8, HBP = 6;
    localparam int VA = 20, VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int N = W * H;
    localparam logic [2:0] BG = 3'b000;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] colour = '0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic       plot = 1'b0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
    logic       fb_ready;
    logic [7:0] drop_count;
    logic [28:0] got;

    logic [2:0] mdl [N];
    int k = 0;
    int drops = 0;
    int checks = 0;
    int passed = 0;

    vga_frame_scanner #(
        .FB_W(W), .FB_H(H), .BG_COLOUR(BG),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clock(clock), .resetn(resetn), .colour(colour), .x(x), .y(y), .plot(plot),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK),
        .fb_ready(fb_ready), .drop_count(drop_count)
    );

    assign got = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK};

    always #10 clock = ~clock;

    initial begin
        #(100_000 * 20);
        $display("FAIL watchdog expired at k=%0d", k);
        $fatal(1);
    end

    // k counts clocks since reset release; the sweep owns edges 1..N.
    task automatic tick();
        @(posedge clock);
        if (!resetn) begin
            k = 0;
            drops = 0;
        end else begin
            k++;
            if (k <= N) mdl[k-1] = BG;
            else if (plot) begin
                if (x < W && y < H) mdl[y*W + x] = colour;
                else if (drops < 255) drops++;
            end
        end
        #1;
    endtask

    // Outputs after clock k show the pixel position reached two ticks earlier.
    function automatic logic [28:0] exp_vec(int kk);
        int p, h, v;
        logic [2:0] c;
        logic act;
        logic [7:0] r, g, b;
        if (kk < 4) return {24'h0, 3'b110, 1'b0, kk[0]};
        p = (kk / 2 - 2) % FRAME;
        h = p % HT;
        v = p / HT;
        act = (h < HA) && (v < VA);
        c = (h < W && v < H) ? mdl[v*W + h] : BG;
        r = (act && c[2]) ? 8'hFF : 8'h00;
        g = (act && c[1]) ? 8'hFF : 8'h00;
        b = (act && c[0]) ? 8'hFF : 8'h00;
        return {r, g, b, !(h >= HA + HFP && h < HA + HFP + HSY),
                !(v >= VA + VFP && v < VA + VFP + VSY), act, 1'b0, kk[0]};
    endfunction

    function automatic int after(input int q[$], input int t);
        foreach (q[j]) if (q[j] > t) return q[j];
        return -1_000_000;
    endfunction

    task automatic watch(input int n, output int errs, output logic [28:0] g, output logic [28:0] e);
        errs = 0;
        g = '0;
        e = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (got !== exp_vec(k) || fb_ready !== (k >= N + 1)) begin
                if (errs == 0) begin
                    g = got;
                    e = exp_vec(k);
                end
                errs++;
            end
        end
    endtask

    task automatic wait_pos(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * FRAME + 8 && !ok; i++) begin
            tick();
            ok = k >= 4 && k % 2 == 0 && (k / 2 - 2) % FRAME == v * HT + h;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        plot = 1'b1;
        x = 10'd3;
        y = 9'd3;
        colour = 3'b101;
        repeat (3) tick();
        checks++;
        if (got !== exp_vec(k)) $display("FAIL reset_outputs got=%h want=%h", got, exp_vec(k));
        else passed++;
        checks++;
        if (fb_ready !== 1'b0) $display("FAIL reset_fb_ready got=%b want=0", fb_ready);
        else passed++;
        checks++;
        if (drop_count !== 8'd0) $display("FAIL reset_drop_count got=%0d want=0", drop_count);
        else passed++;
    endtask

    task automatic test_clear();
        int bad = 0;
        bit ok;
        x = 10'd5;
        y = 9'd5;
        colour = 3'b111;
        plot = 1'b1;
        resetn = 1'b1;
        for (int i = 0; i < N + 1; i++) begin
            tick();
            if (k == N) plot = 1'b0;
            if (fb_ready !== (k >= N + 1)) bad++;
        end
        checks++;
        if (bad != 0 || fb_ready !== 1'b1)
            $display("FAIL clear_duration bad_clocks=%0d fb_ready=%b want 0 then 1 at clock %0d", bad, fb_ready, N + 1);
        else passed++;
        checks++;
        if (drop_count !== 8'd0) $display("FAIL clear_plot_ignored drop_count=%0d want=0", drop_count);
        else passed++;
        wait_pos(5, 5, ok);
        checks++;
        if (!ok || {VGA_R, VGA_G, VGA_B} !== 24'h0)
            $display("FAIL clear_pixel_5_5 found=%b rgb=%h want=000000", ok, {VGA_R, VGA_G, VGA_B});
        else passed++;
    endtask

    task automatic test_sync();
        int errs = 0, blank_cnt = 0, hf0, vf0, bf0;
        int hs_f[$], hs_r[$], vs_f[$], vs_r[$], bl_f[$];
        logic hs_p, vs_p, bl_p;
        logic [28:0] g = '0, e = '0;
        hs_p = VGA_HS;
        vs_p = VGA_VS;
        bl_p = VGA_BLANK_N;
        for (int i = 0; i < 4 * FRAME + 8; i++) begin
            tick();
            if (got !== exp_vec(k)) begin
                if (errs == 0) begin
                    g = got;
                    e = exp_vec(k);
                end
                errs++;
            end
            if (hs_p && !VGA_HS) hs_f.push_back(i);
            if (!hs_p && VGA_HS) hs_r.push_back(i);
            if (vs_p && !VGA_VS) vs_f.push_back(i);
            if (!vs_p && VGA_VS) vs_r.push_back(i);
            if (bl_p && !VGA_BLANK_N) bl_f.push_back(i);
            if (vs_f.size() == 1 && VGA_BLANK_N) blank_cnt++;
            hs_p = VGA_HS;
            vs_p = VGA_VS;
            bl_p = VGA_BLANK_N;
        end
        hf0 = hs_f.size() > 0 ? hs_f[0] : -1;
        vf0 = vs_f.size() > 0 ? vs_f[0] : -1;
        bf0 = bl_f.size() > 0 ? bl_f[0] : -1;
        checks++;
        if (errs != 0) $display("FAIL sync_scan errs=%0d got=%h want=%h", errs, g, e);
        else passed++;
        checks++;
        if (after(hs_r, hf0) - hf0 != 2 * HSY)
            $display("FAIL hs_width clocks=%0d want=%0d", after(hs_r, hf0) - hf0, 2 * HSY);
        else passed++;
        checks++;
        if (after(hs_f, hf0) - hf0 != 2 * HT)
            $display("FAIL hs_period clocks=%0d want=%0d", after(hs_f, hf0) - hf0, 2 * HT);
        else passed++;
        checks++;
        if (after(vs_r, vf0) - vf0 != 2 * VSY * HT)
            $display("FAIL vs_width clocks=%0d want=%0d", after(vs_r, vf0) - vf0, 2 * VSY * HT);
        else passed++;
        checks++;
        if (after(vs_f, vf0) - vf0 != 2 * FRAME)
            $display("FAIL vs_period clocks=%0d want=%0d", after(vs_f, vf0) - vf0, 2 * FRAME);
        else passed++;
        checks++;
        if (blank_cnt != 2 * HA * VA) $display("FAIL blank_count clocks=%0d want=%0d", blank_cnt, 2 * HA * VA);
        else passed++;
        checks++;
        if (after(hs_f, bf0) - bf0 != 2 * HFP)
            $display("FAIL blank_hs_align clocks=%0d want=%0d", after(hs_f, bf0) - bf0, 2 * HFP);
        else passed++;
    endtask

    task automatic test_writes();
        int errs;
        bit ok;
        logic [28:0] g, e;
        for (int i = 0; i < 40; i++) begin
            plot = $urandom_range(0, 3) != 0;
            x = 10'($urandom_range(0, W - 1));
            y = 9'($urandom_range(0, H - 1));
            colour = 3'($urandom);
            tick();
        end
        plot = 1'b1;
        x = 10'd0;
        y = 9'd0;
        colour = 3'b100;
        tick();
        x = 10'(W - 1);
        y = 9'(H - 1);
        colour = 3'b010;
        tick();
        plot = 1'b0;
        repeat (4) tick();
        watch(2 * FRAME + 4, errs, g, e);
        checks++;
        if (errs != 0) $display("FAIL write_scan errs=%0d got=%h want=%h", errs, g, e);
        else passed++;
        wait_pos(0, 0, ok);
        checks++;
        if (!ok || {VGA_R, VGA_G, VGA_B} !== 24'hFF0000)
            $display("FAIL pixel_0_0 found=%b rgb=%h want=ff0000", ok, {VGA_R, VGA_G, VGA_B});
        else passed++;
        wait_pos(W - 1, H - 1, ok);
        checks++;
        if (!ok || {VGA_R, VGA_G, VGA_B} !== 24'h00FF00)
            $display("FAIL pixel_last found=%b rgb=%h want=00ff00", ok, {VGA_R, VGA_G, VGA_B});
        else passed++;
        wait_pos(W, H - 1, ok);
        checks++;
        if (!ok || {VGA_R, VGA_G, VGA_B} !== {{8{BG[2]}}, {8{BG[1]}}, {8{BG[0]}}})
            $display("FAIL pixel_outside found=%b rgb=%h want=background", ok, {VGA_R, VGA_G, VGA_B});
        else passed++;
    endtask

    task automatic test_drops();
        int errs;
        logic [28:0] g, e;
        plot = 1'b1;
        colour = 3'b111;
        x = 10'(W);
        y = 9'd0;
        tick();
        x = 10'd5;
        y = 9'(H);
        tick();
        x = 10'd1023;
        y = 9'd2;
        tick();
        plot = 1'b0;
        tick();
        checks++;
        if (drop_count !== 8'(drops) || drops != 3) $display("FAIL drop_three got=%0d want=%0d", drop_count, drops);
        else passed++;
        for (int i = 0; i < 300; i++) begin
            plot = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                x = 10'($urandom_range(W, 1023));
                y = 9'($urandom_range(0, 511));
            end else begin
                x = 10'($urandom_range(0, 1023));
                y = 9'($urandom_range(H, 511));
            end
            colour = 3'($urandom);
            tick();
        end
        plot = 1'b0;
        tick();
        checks++;
        if (drop_count !== 8'(drops)) $display("FAIL drop_saturate got=%0d want=%0d", drop_count, drops);
        else passed++;
        watch(2 * FRAME + 4, errs, g, e);
        checks++;
        if (errs != 0) $display("FAIL drop_ram_unchanged errs=%0d got=%h want=%h", errs, g, e);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int errs, bad = 0;
        bit ok;
        logic [28:0] g, e;
        plot = 1'b1;
        x = 10'd0;
        y = 9'd0;
        colour = 3'b111;
        tick();
        for (int i = 0; i < 10; i++) begin
            x = 10'($urandom_range(1, W - 1));
            y = 9'($urandom_range(0, H - 1));
            colour = 3'($urandom_range(1, 7));
            tick();
        end
        plot = 1'b0;
        repeat (37) tick();
        resetn = 1'b0;
        tick();
        checks++;
        if (fb_ready !== 1'b0) $display("FAIL midreset_fb_ready got=%b want=0", fb_ready);
        else passed++;
        checks++;
        if (got !== exp_vec(k)) $display("FAIL midreset_outputs got=%h want=%h", got, exp_vec(k));
        else passed++;
        resetn = 1'b1;
        for (int i = 0; i < N + 1; i++) begin
            tick();
            if (fb_ready !== (k >= N + 1)) bad++;
        end
        checks++;
        if (bad != 0 || fb_ready !== 1'b1) $display("FAIL midreset_clear bad_clocks=%0d fb_ready=%b", bad, fb_ready);
        else passed++;
        repeat (4) tick();
        watch(2 * FRAME + 4, errs, g, e);
        checks++;
        if (errs != 0) $display("FAIL midreset_erased errs=%0d got=%h want=%h", errs, g, e);
        else passed++;
        wait_pos(0, 0, ok);
        checks++;
        if (!ok || {VGA_R, VGA_G, VGA_B} !== 24'h0)
            $display("FAIL midreset_pixel_0_0 found=%b rgb=%h want=000000", ok, {VGA_R, VGA_G, VGA_B});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_sync();
        test_writes();
        test_drops();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/vga_frame_scanner.md
# vga_frame_scanner

Downstream of the board renderer: captures the renderer's pixel-write stream (colour, x, y, plot) into an on-chip 3-bit framebuffer and continuously scans it out as 640x480@60 Hz VGA. The block runs from the 50 MHz system clock and uses an internal divide-by-2 pixel enable, so the whole design stays in one clock domain. After reset it clears the framebuffer to a background colour before it accepts any writes.

## Interface
- FB_W, 361: framebuffer width in pixels (renderer x range 0..360)
- FB_H, 241: framebuffer height in pixels (renderer y range 0..240)
- BG_COLOUR, 3'b000: clear colour, and the colour shown outside the framebuffer region
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48: horizontal timing, in pixel ticks
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33: vertical timing, in lines
- clock  in  1  system clock, 50 MHz
- resetn  in  1  reset; one clock, synchronous, active-low
- colour  in  3  write pixel colour {R,G,B}
- x  in  10  write column
- y  in  9  write row
- plot  in  1  write strobe; one write per cycle while high
- VGA_R, VGA_G, VGA_B  out  8 each  channel value; each colour bit expands to 8'hFF or 8'h00
- VGA_HS, VGA_VS  out  1 each  sync signals, active-low
- VGA_BLANK_N  out  1  high during the active region
- VGA_SYNC_N  out  1  constant 0
- VGA_CLK  out  1  pixel clock, clock/2, registered
- fb_ready  out  1  high once the clear sweep is complete
- drop_count  out  8  saturating count of dropped out-of-range writes

## Operation
- Storage: FB_W*FB_H x 3-bit simple dual-port RAM with one write port and one synchronous read port (1-clock latency).
  - Address = y*FB_W + x, 17 bits (87001 entries).
- Control FSM has two states, CLEAR and RUN.
  - Reset enters CLEAR and sets clr_addr to 0.
  - In CLEAR, one BG_COLOUR write per clock at clr_addr, then clr_addr increments. All plot inputs are ignored and are not counted.
  - When clr_addr reaches FB_W*FB_H-1, that final write occurs and the FSM moves to RUN. fb_ready goes high on the next clock.
  - In RUN, plot=1 with x<FB_W and y<FB_H writes colour at the same clock.
  - In RUN, plot=1 with x or y out of range is dropped, and drop_count increments, saturating at 255.
- Scan counters: hcnt 0..799 and vcnt 0..524 advance only on clocks where pix_en=1. pix_en toggles every clock, and VGA_CLK = ~pix_en registered.
  - hcnt wraps at 799. vcnt increments on that wrap and wraps at 524.
- Region definitions:
  - Active region: hcnt<640 and vcnt<480.
  - HS low for hcnt in 656..751. VS low for vcnt in 490..491.
  - In-FB region: hcnt<FB_W and vcnt<FB_H.
- Scanout runs in both CLEAR and RUN.
  - Active and in-FB: the pixel shows the RAM contents.
  - Active, outside FB: the pixel shows BG_COLOUR.
  - Outside the active region: RGB=0 and BLANK_N=0.
- Read-during-write to the same address returns the old data.

## Timing
- Reset values:
  - VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_SYNC_N=0, VGA_CLK=0.
  - fb_ready=0, drop_count=0, hcnt=vcnt=0, pix_en=0.
- Reset during CLEAR or RUN: the FSM returns to CLEAR, the sweep restarts at address 0, and outputs return to their reset values on the next clock.
- Clear duration: fb_ready rises exactly FB_W*FB_H+1 clocks after resetn deasserts.
- Scan pipeline, in pixel ticks:
  - tick 0: counters.
  - tick 1: registered RAM address, in-FB flag, active flag, raw HS/VS.
  - tick 2: output registers.
  - RGB, HS, VS and BLANK_N are therefore all delayed by exactly 2 pixel ticks (4 clocks) from the counter values and stay mutually aligned.
- Outputs change only on clocks where pix_en=1.
- Frame period: 800*525 pixel ticks = 840000 clocks.
- Write latency: a write accepted at clock n is visible on the read port from clock n+1.

## Test plan
- Reset release -> fb_ready=0 for 87001 clocks, then 1. A random sample of RAM addresses reads 3'b000.
- Sync timing over 2 frames:
  - HS low pulse = 96 ticks, period = 800 ticks.
  - VS low = 2 lines, period = 525 lines.
  - BLANK_N high 640 of 800 ticks on lines 0..479.
  - HS/VS/BLANK edges are aligned to the 2-tick pipeline.
- RUN: write colour=3'b100 at (0,0) and 3'b010 at (360,240).
  - Next frame: the first active pixel of line 0 is R=FF, G=00, B=00.
  - Pixel 360 of line 240 is G=FF.
  - Pixel 361 of line 240 is BG_COLOUR.
- Out-of-range writes: plot with x=361, then y=241, then x=1023, each 1 clock.
  - drop_count=3, and no RAM location changes.
  - 300 further drops -> drop_count holds at 255.
- Plot held high during CLEAR with (5,5)=3'b111.
  - Ignored: drop_count=0, and pixel (5,5) shows 000 after fb_ready.
- Reset asserted mid-RUN after writes.
  - fb_ready drops the next clock, and the HS/VS/RGB outputs return to their reset values.
  - After the 87001-clock clear, all earlier writes are erased.
